// File: rtl/mips_ctrl_pkg.sv
// Shared opcode/funct values, status codes, FSM states and instruction classes
// for the multi-cycle MIPS control unit.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BMN   = 6'd21;
  localparam logic [5:0] OP_BZ    = 6'd24;
  localparam logic [5:0] OP_JALM  = 6'd19;
  localparam logic [5:0] OP_JSPAL = 6'd22;
  localparam logic [5:0] FN_BRZ   = 6'd20;
  localparam logic [5:0] FN_JMOR  = 6'd37;

  localparam logic [2:0] ST_NONE  = 3'b000;
  localparam logic [2:0] ST_BMN   = 3'b001;
  localparam logic [2:0] ST_BRZ   = 3'b010;
  localparam logic [2:0] ST_BZ    = 3'b011;
  localparam logic [2:0] ST_JMOR  = 3'b100;
  localparam logic [2:0] ST_JALM  = 3'b101;
  localparam logic [2:0] ST_JSPAL = 3'b110;
  localparam logic [2:0] ST_BEQ   = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WR   = 4'd4,
    S_WB_MEM   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_WB_R     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP_EXT = 4'd9,
    S_DONE     = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  typedef enum logic [3:0] {
    C_RTYPE, C_LW, C_SW, C_BEQ, C_BMN, C_BRZ, C_BZ,
    C_JMOR, C_JALM, C_JSPAL, C_ILLEGAL
  } iclass_t;

endpackage

// File: rtl/mips_mc_control_if.sv
// Shared-memory request/ready handshake between the control FSM and memory.
interface mips_mc_control_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, mem_we, iord, input mem_ready);
  modport slave  (input mem_req, mem_we, iord, output mem_ready);
endinterface

// File: rtl/mips_ctrl_decode.sv
// Combinational instruction classifier: opcode/funct -> class and status code.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
#(
  parameter int EXT_EN = 1
) (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    iclass,
  output logic [2:0] status
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    iclass = C_ILLEGAL;
    status = ST_NONE;
    case (opcode)
      OP_RTYPE: begin
        if (funct == FN_BRZ) begin
          iclass = C_BRZ;  status = ST_BRZ;
        end else if (funct == FN_JMOR) begin
          iclass = C_JMOR; status = ST_JMOR;
        end else begin
          iclass = C_RTYPE;
        end
      end
      OP_LW:    iclass = C_LW;
      OP_SW:    iclass = C_SW;
      OP_BEQ:   begin iclass = C_BEQ;   status = ST_BEQ;   end
      OP_BMN:   begin iclass = C_BMN;   status = ST_BMN;   end
      OP_BZ:    begin iclass = C_BZ;    status = ST_BZ;    end
      OP_JALM:  begin iclass = C_JALM;  status = ST_JALM;  end
      OP_JSPAL: begin iclass = C_JSPAL; status = ST_JSPAL; end
      default:  ;
    endcase
    // Extended ops trap as illegal when the extension is disabled.
    if (EXT_EN == 0 && iclass inside {C_BMN, C_BRZ, C_BZ, C_JMOR, C_JALM, C_JSPAL}) begin
      iclass = C_ILLEGAL;
      status = ST_NONE;
    end
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// around a req/ready memory, with timeout trap and retired-instruction counter.
module mips_mc_control
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16,
  parameter int EXT_EN      = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  mips_mc_control_if.master mem,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic [2:0]       status,
  output logic             err,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] retired
);

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state, state_n;
  iclass_t    dec_class, iclass_q;
  logic [2:0] dec_status;
  logic [7:0] tmo_cnt;
  logic       mem_wait, timeout;

  mips_ctrl_decode #(.EXT_EN(EXT_EN)) u_decode (
    .opcode (opcode),
    .funct  (funct),
    .iclass (dec_class),
    .status (dec_status)
  );

  always_comb begin
    state_n       = state;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.iord      = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'd0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op        = 2'd0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    mem_wait      = state inside {S_FETCH, S_MEM_RD, S_MEM_WR};
    timeout       = mem_wait && !mem.mem_ready && (tmo_cnt == TMO_LAST);

    // NOTE: decoding is gated by rst_n so an in-flight request drops the
    // moment reset asserts, without waiting for a clock edge.
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          mem.mem_req = 1'b1;
          alu_src_b   = 2'd1;
          if (mem.mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_n  = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src_b = 2'd3;
          case (dec_class)
            C_LW, C_SW, C_BMN, C_JALM: state_n = S_MEM_ADDR;
            C_RTYPE:                   state_n = S_EXEC_R;
            C_BRZ, C_JMOR, C_JSPAL:    state_n = S_JUMP_EXT;
            C_BEQ, C_BZ:               state_n = S_BRANCH;
            default:                   state_n = S_HALT;
          endcase
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          state_n   = (iclass_q == C_SW) ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD: begin
          mem.mem_req = 1'b1;
          mem.iord    = 1'b1;
          if (mem.mem_ready) state_n = (iclass_q == C_LW) ? S_WB_MEM : S_JUMP_EXT;
        end
        S_MEM_WR: begin
          mem.mem_req = 1'b1;
          mem.mem_we  = 1'b1;
          mem.iord    = 1'b1;
          if (mem.mem_ready) state_n = S_DONE;
        end
        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          state_n    = S_DONE;
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = 2'd2;
          state_n   = S_WB_R;
        end
        S_WB_R: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          state_n   = S_DONE;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'd1;
          pc_write_cond = 1'b1;
          pc_source     = 2'd1;
          state_n       = S_DONE;
        end
        S_JUMP_EXT: begin
          pc_write_cond = 1'b1;
          pc_source     = (iclass_q inside {C_BMN, C_JALM, C_JMOR}) ? 2'd2 : 2'd1;
          if (iclass_q inside {C_JMOR, C_JALM, C_JSPAL}) begin
            reg_write  = 1'b1;
            reg_dst    = 1'b1;
            mem_to_reg = 1'b1;
          end
          state_n = S_DONE;
        end
        S_DONE:  state_n = S_FETCH;
        S_HALT:  ;
        default: state_n = S_HALT;
      endcase
      if (timeout) state_n = S_HALT;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      iclass_q <= C_RTYPE;
      status   <= ST_NONE;
      tmo_cnt  <= 8'd0;
      err      <= 1'b0;
      retired  <= '0;
    end else begin
      state   <= state_n;
      tmo_cnt <= (mem_wait && !mem.mem_ready && !timeout) ? tmo_cnt + 8'd1 : 8'd0;
      if (state == S_DECODE) begin
        status   <= dec_status;
        iclass_q <= dec_class;
      end
      if (state_n == S_HALT && state != S_HALT) err <= 1'b1;
      if (state == S_DONE) retired <= retired + 1'b1;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_mips_mc_control.sv
// Self-checking bench for mips_mc_control: table-driven instruction runs with a
// scoreboard queue, plus hand-written timeout, trap, wrap and reset sequences.
module tb_mips_mc_control;
  import mips_ctrl_pkg::*;

  typedef struct {
    int op, fn, dly;
    int st, cyc, rw, rd, m2r, pwc, psrc, req, we, ret;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic ready = 1'b0;

  mips_mc_control_if bus0 ();
  mips_mc_control_if bus1 ();
  assign bus0.mem_ready = ready;
  assign bus1.mem_ready = ready;

  logic       ir_write, pc_write, pc_write_cond, alu_src_a, reg_write, reg_dst, mem_to_reg, err;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic [2:0] status;
  logic [3:0] state_o, retired;

  logic       x_ir_write, x_pc_write, x_pc_write_cond, x_alu_src_a, x_reg_write, x_reg_dst;
  logic       x_mem_to_reg, x_err;
  logic [1:0] x_pc_source, x_alu_src_b, x_alu_op;
  logic [2:0] x_status;
  logic [3:0] x_state_o, x_retired;

  mips_mc_control #(.MEM_TIMEOUT(4), .CNT_W(4), .EXT_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem(bus0.master),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .status(status), .err(err), .state_o(state_o),
    .retired(retired)
  );

  mips_mc_control #(.MEM_TIMEOUT(4), .CNT_W(4), .EXT_EN(0)) dut_noext (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem(bus1.master),
    .ir_write(x_ir_write), .pc_write(x_pc_write), .pc_write_cond(x_pc_write_cond),
    .pc_source(x_pc_source), .alu_src_a(x_alu_src_a), .alu_src_b(x_alu_src_b),
    .alu_op(x_alu_op), .reg_write(x_reg_write), .reg_dst(x_reg_dst),
    .mem_to_reg(x_mem_to_reg), .status(x_status), .err(x_err), .state_o(x_state_o),
    .retired(x_retired)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   exp_ret = 0;
  vec_t sb[$];
  vec_t tbl[12];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Ends at a falling edge with the DUT in its first FETCH cycle.
  task automatic do_reset();
    rst_n = 1'b0;
    ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    exp_ret = 0;
  endtask

  // Runs one instruction from FETCH to DONE, answering each memory access
  // after v.dly wait cycles; called and returns at a falling edge in FETCH.
  task automatic run_instr(input vec_t v);
    vec_t e;
    int   s, wcnt, done;
    int   cyc, rw, rd, m2r, pwc, psrc, req, we, st_done, ret_done;
    e = v;
    e.ret = exp_ret;
    sb.push_back(e);
    exp_ret = (exp_ret + 1) % 16;
    opcode = 6'(v.op);
    funct  = 6'(v.fn);
    wcnt = 0; done = 0; cyc = 0; rw = 0; rd = 0; m2r = 0; pwc = 0; psrc = 0;
    req = 0; we = 0; st_done = -1; ret_done = -1;
    for (int c = 0; c < 100; c++) begin
      s = int'(state_o);
      if (s == int'(S_FETCH) || s == int'(S_MEM_RD) || s == int'(S_MEM_WR)) begin
        ready = (wcnt == v.dly);
        if (ready) wcnt = 0;
        else wcnt++;
      end else begin
        ready = 1'b0;
      end
      #1;
      cyc++;
      if (reg_write) rw++;
      if (reg_write && reg_dst) rd++;
      if (reg_write && mem_to_reg) m2r++;
      if (pc_write_cond) begin pwc++; psrc = int'(pc_source); end
      if (bus0.mem_req) req++;
      if (bus0.mem_we) we++;
      if (s == int'(S_DONE)) begin
        done = 1; st_done = int'(status); ret_done = int'(retired);
        break;
      end
      if (s == int'(S_HALT)) break;
      @(negedge clk);
    end
    e = sb.pop_front();
    check($sformatf("op%0d/%0d reached_done", e.op, e.fn), done, 1);
    check($sformatf("op%0d/%0d cycles", e.op, e.fn), cyc, e.cyc);
    check($sformatf("op%0d/%0d status", e.op, e.fn), st_done, e.st);
    check($sformatf("op%0d/%0d reg_write_cycles", e.op, e.fn), rw, e.rw);
    check($sformatf("op%0d/%0d reg_dst_cycles", e.op, e.fn), rd, e.rd);
    check($sformatf("op%0d/%0d mem_to_reg_cycles", e.op, e.fn), m2r, e.m2r);
    check($sformatf("op%0d/%0d pc_write_cond_cycles", e.op, e.fn), pwc, e.pwc);
    check($sformatf("op%0d/%0d pc_source", e.op, e.fn), psrc, e.psrc);
    check($sformatf("op%0d/%0d mem_req_cycles", e.op, e.fn), req, e.req);
    check($sformatf("op%0d/%0d mem_we_cycles", e.op, e.fn), we, e.we);
    check($sformatf("op%0d/%0d retired", e.op, e.fn), ret_done, e.ret);
    ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    //          op  fn dly st cyc rw rd m2r pwc psrc req we ret
    tbl[0]  = '{0,  32, 0, 0, 5,  1, 1, 0,  0,  0,   1,  0, 0}; // R add
    tbl[1]  = '{35, 0,  0, 0, 6,  1, 0, 1,  0,  0,   2,  0, 0}; // lw
    tbl[2]  = '{35, 0,  3, 0, 12, 1, 0, 1,  0,  0,   8,  0, 0}; // lw, 3 waits
    tbl[3]  = '{43, 0,  0, 0, 5,  0, 0, 0,  0,  0,   2,  1, 0}; // sw
    tbl[4]  = '{43, 0,  2, 0, 9,  0, 0, 0,  0,  0,   6,  3, 0}; // sw, 2 waits
    tbl[5]  = '{4,  0,  0, 7, 4,  0, 0, 0,  1,  1,   1,  0, 0}; // beq
    tbl[6]  = '{24, 0,  0, 3, 4,  0, 0, 0,  1,  1,   1,  0, 0}; // bz
    tbl[7]  = '{22, 0,  0, 6, 4,  1, 1, 1,  1,  1,   1,  0, 0}; // jspal
    tbl[8]  = '{0,  20, 0, 2, 4,  0, 0, 0,  1,  1,   1,  0, 0}; // brz
    tbl[9]  = '{0,  37, 0, 4, 4,  1, 1, 1,  1,  2,   1,  0, 0}; // jmor
    tbl[10] = '{21, 0,  0, 1, 6,  0, 0, 0,  1,  2,   2,  0, 0}; // bmn
    tbl[11] = '{19, 0,  0, 5, 6,  1, 1, 1,  1,  2,   2,  0, 0}; // jalm

    // Reset state, with mem_ready high to show outputs stay gated.
    ready = 1'b1;
    #12;
    check("rst mem_req", int'(bus0.mem_req), 0);
    check("rst ir_write", int'(ir_write), 0);
    check("rst alu_src_b", int'(alu_src_b), 0);
    check("rst state", int'(state_o), int'(S_FETCH));
    check("rst err", int'(err), 0);
    check("rst status", int'(status), 0);
    check("rst retired", int'(retired), 0);

    do_reset();
    for (int i = 0; i < 12; i++) run_instr(tbl[i]);
    #1 check("retired after table", int'(retired), 12);

    // Timeout: no mem_ready in FETCH traps after 4 wait cycles.
    do_reset();
    repeat (3) @(negedge clk);
    #1 check("tmo 3 waits state", int'(state_o), int'(S_FETCH));
    check("tmo 3 waits err", int'(err), 0);
    @(negedge clk);
    #1 check("tmo 4 waits state", int'(state_o), int'(S_HALT));
    check("tmo 4 waits err", int'(err), 1);
    ready = 1'b1;
    n = 0;
    repeat (3) begin
      @(negedge clk);
      #1 if (bus0.mem_req) n++;
    end
    check("halt no mem_req", n, 0);
    check("halt absorbing", int'(state_o), int'(S_HALT));

    // mem_ready in exactly the 4th FETCH cycle wins over the timeout.
    do_reset();
    repeat (3) @(negedge clk);
    ready = 1'b1;
    #1 check("tmo edge ir_write", int'(ir_write), 1);
    @(negedge clk);
    #1 check("tmo edge state", int'(state_o), int'(S_DECODE));
    check("tmo edge err", int'(err), 0);

    // Illegal opcode traps; reset clears it.
    do_reset();
    opcode = 6'd63; funct = 6'd0; ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 check("illegal state", int'(state_o), int'(S_HALT));
    check("illegal err", int'(err), 1);
    n = 0;
    repeat (3) begin
      @(negedge clk);
      #1 if (bus0.mem_req) n++;
    end
    check("illegal no mem_req", n, 0);
    rst_n = 1'b0;
    #1 check("illegal rst err", int'(err), 0);
    check("illegal rst state", int'(state_o), int'(S_FETCH));

    // bmn with extensions disabled traps only in the EXT_EN=0 instance.
    do_reset();
    opcode = OP_BMN; funct = 6'd0; ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 check("noext bmn state", int'(x_state_o), int'(S_HALT));
    check("noext bmn err", int'(x_err), 1);
    check("ext bmn state", int'(state_o), int'(S_MEM_ADDR));
    check("ext bmn err", int'(err), 0);
    n = 0;
    repeat (4) begin
      @(negedge clk);
      #1 if (bus1.mem_req) n++;
    end
    check("noext no mem_req", n, 0);
    rst_n = 1'b0;
    #1 check("noext rst err", int'(x_err), 0);

    // 17 stores wrap the 4-bit retired counter to 1.
    do_reset();
    for (int i = 0; i < 17; i++) run_instr(tbl[3]);
    #1 check("retired wrap", int'(retired), 1);

    // Reset during MEM_WR drops mem_req asynchronously.
    do_reset();
    opcode = OP_SW; funct = 6'd0; ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    n = 0;
    while (state_o != S_MEM_WR && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("reach MEM_WR", int'(state_o), int'(S_MEM_WR));
    #1 check("MEM_WR mem_req", int'(bus0.mem_req), 1);
    #2 rst_n = 1'b0;
    #1 check("async rst mem_req", int'(bus0.mem_req), 0);
    check("async rst state", int'(state_o), int'(S_FETCH));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time limit expired");
    $fatal(1);
  end

endmodule
